// File: rtl/blake2s_msg_feeder.sv
// Host-side byte feeder for the byte-serial BLAKE2s core.
// Cuts an upstream byte stream into 64-byte blocks and zero-pads the final one.
module blake2s_msg_feeder #(
    parameter int IDX_W = 6,
    parameter int LL_W  = 64
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             s_valid_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_last_i,
    input  logic             s_empty_i,
    output logic             s_ready_o,
    input  logic [5:0]       nn_i,
    input  logic             core_ready_v_i,
    output logic [5:0]       core_kk_o,
    output logic [5:0]       core_nn_o,
    output logic [LL_W-1:0]  core_ll_o,
    output logic             core_block_first_o,
    output logic             core_block_last_o,
    output logic             core_data_v_o,
    output logic [IDX_W-1:0] core_data_idx_o,
    output logic [7:0]       core_data_o,
    output logic             busy_o,
    output logic             msg_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_PAD
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    state_t           state_q;
    logic [IDX_W-1:0] wr_idx_q;

    logic             ready_c;
    logic             accept;
    logic             is_empty;
    logic [IDX_W-1:0] beat_idx;
    logic [IDX_W-1:0] beat_nxt;
    logic             beat_max;

    always_comb begin
        ready_c = 1'b0;
        unique case (state_q)
            ST_IDLE:   ready_c = core_ready_v_i;
            ST_WAIT:   ready_c = core_ready_v_i;
            ST_STREAM: ready_c = 1'b1;
            ST_PAD:    ready_c = 1'b0;
            default:   ready_c = 1'b0;
        endcase
    end

    // Gate with reset so upstream never sees ready while the block is held.
    assign s_ready_o = nreset & ready_c;
    assign accept    = s_valid_i & s_ready_o;

    // Only the opening beat of a message may be an empty marker.
    assign is_empty = (state_q == ST_IDLE) & s_empty_i & s_last_i;

    // IDLE and WAIT both open a fresh block at idx 0.
    assign beat_idx = (state_q == ST_STREAM) ? wr_idx_q : '0;
    assign beat_nxt = beat_idx + 1'b1;
    assign beat_max = (beat_idx == IDX_MAX);

    assign core_kk_o = 6'd0;
    assign busy_o    = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q            <= ST_IDLE;
            wr_idx_q           <= '0;
            core_nn_o          <= '0;
            core_ll_o          <= '0;
            core_block_first_o <= 1'b0;
            core_block_last_o  <= 1'b0;
            core_data_v_o      <= 1'b0;
            core_data_idx_o    <= '0;
            core_data_o        <= '0;
            msg_done_o         <= 1'b0;
        end else begin
            core_data_v_o <= 1'b0;
            msg_done_o    <= 1'b0;
            if (state_q == ST_PAD) begin
                core_data_v_o   <= 1'b1;
                core_data_idx_o <= wr_idx_q;
                core_data_o     <= 8'h00;
                wr_idx_q        <= wr_idx_q + 1'b1;
                if (wr_idx_q == IDX_MAX) begin
                    msg_done_o <= 1'b1;
                    state_q    <= ST_IDLE;
                end
            end else if (accept) begin
                core_data_v_o     <= 1'b1;
                core_data_idx_o   <= beat_idx;
                core_block_last_o <= s_last_i;
                wr_idx_q          <= beat_nxt;
                if (state_q == ST_IDLE) begin
                    core_nn_o          <= nn_i;
                    core_block_first_o <= 1'b1;
                end else if (state_q == ST_WAIT) begin
                    core_block_first_o <= 1'b0;
                end
                if (is_empty) begin
                    // Empty message: idx 0 goes out as the first pad byte.
                    core_data_o <= 8'h00;
                    core_ll_o   <= '0;
                    state_q     <= ST_PAD;
                end else begin
                    core_data_o <= s_data_i;
                    if (state_q == ST_IDLE) begin
                        core_ll_o <= LL_W'(1);
                    end else begin
                        core_ll_o <= core_ll_o + LL_W'(1);
                    end
                    if (beat_max) begin
                        if (s_last_i) begin
                            msg_done_o <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (s_last_i) begin
                        state_q <= ST_PAD;
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_blake2s_msg_feeder.sv
// Directed bench for blake2s_msg_feeder: table of messages plus
// hand-written ready-stall and mid-block reset sequences.
module tb_blake2s_msg_feeder;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        s_empty = 1'b0;
    logic        s_ready;
    logic [5:0]  nn = 6'd0;
    logic        core_ready = 1'b1;
    logic [5:0]  kk_o;
    logic [5:0]  nn_o;
    logic [63:0] ll_o;
    logic        first_o;
    logic        last_o;
    logic        data_v_o;
    logic [5:0]  idx_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int failures = 0;

    blake2s_msg_feeder #(.IDX_W(6), .LL_W(64)) dut (
        .clk                (clk),
        .nreset             (nreset),
        .s_valid_i          (s_valid),
        .s_data_i           (s_data),
        .s_last_i           (s_last),
        .s_empty_i          (s_empty),
        .s_ready_o          (s_ready),
        .nn_i               (nn),
        .core_ready_v_i     (core_ready),
        .core_kk_o          (kk_o),
        .core_nn_o          (nn_o),
        .core_ll_o          (ll_o),
        .core_block_first_o (first_o),
        .core_block_last_o  (last_o),
        .core_data_v_o      (data_v_o),
        .core_data_idx_o    (idx_o),
        .core_data_o        (data_o),
        .busy_o             (busy_o),
        .msg_done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [7:0]  data;
        logic        first;
        logic        last;
        logic        done;
        logic [5:0]  nn;
        logic [63:0] ll;
        int          cyc;
    } beat_t;

    typedef struct {
        string name;
        int    len;
        int    nn;
        bit    empty;
        bit    gaps;
        int    blocks;
        int    ll;
    } vec_t;

    beat_t mon_q[$];
    int    done_cnt = 0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t b;
        if (nreset && data_v_o) begin
            b.idx   = idx_o;
            b.data  = data_o;
            b.first = first_o;
            b.last  = last_o;
            b.done  = done_o;
            b.nn    = nn_o;
            b.ll    = ll_o;
            b.cyc   = cyc;
            mon_q.push_back(b);
        end
        if (nreset && done_o) done_cnt <= done_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int p);
        return 8'(32'h61 + p);
    endfunction

    task automatic wait_accept();
        int w = 0;
        #1;
        while (!s_ready && w < 500) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 500) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no ready expected ready");
        end
        @(negedge clk);
    endtask

    task automatic send(input int from, input int to, input int len,
                        input bit empty, input bit gaps);
        for (int i = from; i < to; i++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                s_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = empty ? 8'h00 : msg_byte(i);
            s_last  = (i == len - 1);
            s_empty = empty;
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_empty = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int w = 0;
        while (done_cnt == d0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " done_seen"}, 128'(done_cnt != d0), 128'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_msg(input string nm, input int base, input int len,
                             input bit empty, input int nnv,
                             input int blocks, input int exp_ll);
        int    n;
        int    ndone;
        int    b;
        int    j;
        int    bll;
        logic  lastblk;
        logic [7:0] ed;
        beat_t r;
        n = mon_q.size() - base;
        ndone = 0;
        chk({nm, " beats"}, 128'(n), 128'(blocks * 64));
        for (int k = 0; k < n && k < blocks * 64; k++) begin
            r  = mon_q[base + k];
            b  = k / 64;
            j  = k % 64;
            ed = (!empty && k < len) ? msg_byte(k) : 8'h00;
            chk($sformatf("%s beat%0d idx_data", nm, k),
                {r.idx, r.data}, {6'(j), ed});
            if (r.done) ndone++;
            if (j == 63) begin
                lastblk = (b == blocks - 1);
                bll = lastblk ? exp_ll : (b + 1) * 64;
                chk($sformatf("%s blk%0d hdr", nm, b),
                    {r.first, r.last, r.done, r.nn, r.ll},
                    {b == 0, lastblk, lastblk, 6'(nnv), 64'(bll)});
            end
            if (k > 0 && k >= len) begin
                chk($sformatf("%s pad%0d timing", nm, k),
                    128'(r.cyc - mon_q[base + k - 1].cyc), 128'(1));
            end
        end
        chk({nm, " done_pulses"}, 128'(ndone), 128'(1));
    endtask

    vec_t vecs[7];
    int   base;
    int   d0;

    initial begin
        vecs[0] = '{"abc",         3,   32, 1'b0, 1'b0, 1, 3};
        vecs[1] = '{"full64",      64,  16, 1'b0, 1'b0, 1, 64};
        vecs[2] = '{"empty",       0,   8,  1'b1, 1'b0, 1, 0};
        vecs[3] = '{"len63",       63,  1,  1'b0, 1'b0, 1, 63};
        vecs[4] = '{"len128",      128, 32, 1'b0, 1'b0, 2, 128};
        vecs[5] = '{"len130_gaps", 130, 28, 1'b0, 1'b1, 3, 130};
        vecs[6] = '{"len1",        1,   4,  1'b0, 1'b0, 1, 1};

        #2;
        chk("reset_outputs",
            {s_ready, kk_o, nn_o, ll_o, first_o, last_o, data_v_o,
             idx_o, data_o, busy_o, done_o}, '0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("idle_ready_hi", 128'(s_ready), 128'(1));
        core_ready = 1'b0;
        #1;
        chk("idle_ready_lo", 128'(s_ready), 128'(0));
        core_ready = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            base = mon_q.size();
            d0   = done_cnt;
            nn   = 6'(vecs[v].nn);
            if (vecs[v].empty) send(0, 1, 1, 1'b1, 1'b0);
            else send(0, vecs[v].len, vecs[v].len, 1'b0, vecs[v].gaps);
            chk({vecs[v].name, " busy_after_last"}, 128'(busy_o),
                128'(vecs[v].empty || (vecs[v].len % 64 != 0)));
            wait_done(vecs[v].name, d0);
            chk({vecs[v].name, " idle_after"}, 128'(busy_o), 128'(0));
            check_msg(vecs[v].name, base, vecs[v].len, vecs[v].empty,
                      vecs[v].nn, vecs[v].blocks, vecs[v].ll);
        end

        // 65 bytes with the core stalling between blocks.
        base = mon_q.size();
        d0   = done_cnt;
        nn   = 6'd20;
        send(0, 64, 65, 1'b0, 1'b0);
        core_ready = 1'b0;
        s_valid    = 1'b1;
        s_data     = msg_byte(64);
        s_last     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("len65 stall%0d ready", i), 128'(s_ready), 128'(0));
            @(negedge clk);
        end
        core_ready = 1'b1;
        send(64, 65, 65, 1'b0, 1'b0);
        wait_done("len65", d0);
        check_msg("len65", base, 65, 1'b0, 20, 2, 65);

        // Reset while idx 20 of block 1 is on the core port.
        nn = 6'd32;
        send(0, 21, 100, 1'b0, 1'b0);
        chk("prereset_idx", {data_v_o, idx_o}, {1'b1, 6'd20});
        nreset = 1'b0;
        #1;
        chk("midblock_reset",
            {s_ready, kk_o, nn_o, ll_o, first_o, last_o, data_v_o,
             idx_o, data_o, busy_o, done_o}, '0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        base = mon_q.size();
        d0   = done_cnt;
        send(0, 3, 3, 1'b0, 1'b0);
        wait_done("abc_after_reset", d0);
        check_msg("abc_after_reset", base, 3, 1'b0, 32, 1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blake2s_msg_feeder.md
# blake2s_msg_feeder

Host-side driver for the byte-serial BLAKE2s core (`blake2s_hash256`). It accepts a message as a valid/ready byte stream and cuts it into 64-byte blocks. For each block it drives the core's `data_v/data_idx/data` write port and the `block_first/block_last/ll/nn/kk` qualifiers, zero-padding the final block. Between blocks it honours the core's `ready_v` block handshake. It sits between the message source (DMA/UART unpacker) and the hash core. Digest readback is out of scope.

## Interface
- `IDX_W`, default 6, byte-index width; block size is 2**IDX_W = 64 bytes.
- `LL_W`, default 64, byte-counter width (BLAKE2s `t`).
- `clk`  in  1  clock.
- `nreset`  in  1  asynchronous, active-low reset.
- `s_valid_i`  in  1  upstream byte valid.
- `s_data_i`  in  8  upstream byte.
- `s_last_i`  in  1  final beat of message.
- `s_empty_i`  in  1  with `s_last_i` on the first beat of a message: zero-length message, the beat carries no data.
- `s_ready_o`  out  1  upstream beat accepted when `s_valid_i & s_ready_o`.
- `nn_i`  in  6  digest length; sampled on the first accepted beat of a message.
- `core_ready_v_i`  in  1  core ready to accept a new block (its `ready_v_o`).
- `core_kk_o`  out  6  key length, constant 0.
- `core_nn_o`  out  6  latched `nn_i`.
- `core_ll_o`  out  LL_W  cumulative message bytes through the current beat.
- `core_block_first_o`  out  1  current block is block 0 of the message.
- `core_block_last_o`  out  1  current block is the final block.
- `core_data_v_o`  out  1  write beat valid.
- `core_data_idx_o`  out  IDX_W  byte index in block.
- `core_data_o`  out  8  byte (0x00 for padding).
- `busy_o`  out  1  message in progress.
- `msg_done_o`  out  1  one-cycle pulse on the idx-63 beat of the final block.

## Operation
- States:
  - IDLE: no message.
  - STREAM: block open, accepting bytes.
  - WAIT: block full, message not ended, waiting for the core.
  - PAD: emitting zero bytes to idx 63.
- `s_ready_o` = (IDLE|WAIT) & `core_ready_v_i`, or STREAM. It is 0 in PAD.
- IDLE, accepted beat:
  - Latch `nn_i`, set first=1, clear ll.
  - If `s_empty_i & s_last_i`: set last=1, ll stays 0, go to PAD starting at idx 0. No data byte is emitted.
  - Otherwise the beat is byte idx 0, ll=1.
- Each accepted data beat: emit the byte at the current idx, then increment ll and idx.
- Block ends at idx 63 with message not ended: go to WAIT. A full 64-byte block with `s_last_i` on idx 63 sets last and returns to IDLE; no padding is added and no extra block is sent.
- `s_last_i` at idx k<63: set last; go to PAD and emit idx k+1..63 with data 0x00. ll is frozen.
- WAIT, accepted beat: start a new block at idx 0 with first=0.
- Leaving the final block: at idx 63, pulse `msg_done_o` and return to IDLE.
- `s_empty_i` is ignored (beat counted as data) unless it is the first beat of a message.
- `core_block_last_o`:
  - Set from the beat carrying `s_last_i` onward.
  - The core samples first/last/ll/nn only on the idx-63 beat, where they are always correct.
- ll wraps modulo 2**LL_W. Wrap is not reachable in practice and is not flagged.

## Timing
- All core-side outputs are registered. A beat accepted in cycle t appears on `core_data_v_o` at t+1.
- Upstream gaps produce `core_data_v_o`=0 cycles mid-block; the core tolerates gaps.
- PAD emits one beat per cycle. With last data idx k accepted at t, pad idx j appears at t+1+(j-k). For an empty message accepted at t, idx 0 appears at t+1 and idx 63 at t+64.
- `s_ready_o` is combinational from state and `core_ready_v_i`.
- Reset values: `s_ready_o`=0 while `nreset` low, then `core_ready_v_i`-dependent in IDLE. All other outputs are 0, including `core_nn_o`, `core_ll_o` and idx.
- `nreset` asserted mid-block aborts immediately. No resume; the core must be reset alongside.
- `core_ready_v_i` is sampled only in IDLE/WAIT. Dropping it during STREAM/PAD has no effect.

## Test plan
- "abc" (0x61,0x62,0x63, last on 0x63), nn=32:
  - Beats idx0-2 carry the data; idx3-63 are 0x00.
  - idx63 has first=1, last=1, ll=3, nn=32.
  - `msg_done_o` pulses once.
- 64-byte message, last on byte 64: no pad beats; idx63 has first=1, last=1, ll=64; exactly 64 beats total.
- 65-byte message with `core_ready_v_i` held low 10 cycles after block 1:
  - Block 1 idx63 has first=1, last=0, ll=64.
  - `s_ready_o`=0 for those 10 cycles.
  - Block 2 idx0 carries byte 65; idx1-63 are pads; idx63 has first=0, last=1, ll=65.
- Empty message (`s_last_i`=`s_empty_i`=1, first beat):
  - 64 zero beats on consecutive cycles.
  - idx63 has first=1, last=1, ll=0; `msg_done_o` pulses.
- Random upstream valid gaps on a 130-byte message:
  - Byte order and idx are preserved.
  - Block ll values at idx63 are 64, 128, 130; the third block pads idx2-63.
- `nreset` pulsed at idx 20 of block 1: all outputs 0 immediately; after release, a fresh "abc" produces the scenario-1 response.
